channel_mixer: RTL and testbench

CHANNEL_MIXER -- requirements
Module: channel_mixer

---
 rtl/channel_mixer.sv | 142 ++++++++++++++
 tb/tb_channel_mixer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_mixer.sv
// Eight-channel sequential mixer: captures one sample set, accumulates enabled channels
// over eight cycles, then holds the result for an output handshake. Define MIXER_SAT_EN for saturation.
module channel_mixer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sig_in_1,
    input  logic [15:0] sig_in_2,
    input  logic [15:0] sig_in_3,
    input  logic [15:0] sig_in_4,
    input  logic [15:0] sig_in_5,
    input  logic [15:0] sig_in_6,
    input  logic [15:0] sig_in_7,
    input  logic [15:0] sig_in_8,
    input  logic [7:0]  ch_en,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mix_out,
    output logic        sat_flag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [15:0]        cap [8];
    logic [7:0]         en_r;
    logic signed [19:0] acc;
    logic [2:0]         idx;
    logic signed [19:0] term;
    logic signed [19:0] sum;
    logic [15:0]        mix_next;
    logic               accept;
    logic               last_step;

    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (state == ACCUM) && (idx == 3'd7);
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        term = '0;
        if (en_r[idx]) begin
            term = {{4{cap[idx][15]}}, cap[idx]};
        end
        sum = acc + term;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = ACCUM;
            ACCUM:   if (idx == 3'd7) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            idx       <= '0;
            en_r      <= '0;
            mix_out   <= '0;
            out_valid <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                cap[i] <= '0;
            end
        end else begin
            if (accept) begin
                cap[0] <= sig_in_1;
                cap[1] <= sig_in_2;
                cap[2] <= sig_in_3;
                cap[3] <= sig_in_4;
                cap[4] <= sig_in_5;
                cap[5] <= sig_in_6;
                cap[6] <= sig_in_7;
                cap[7] <= sig_in_8;
                en_r   <= ch_en;
                acc    <= '0;
                idx    <= '0;
            end
            if (state == ACCUM) begin
                acc <= sum;
                idx <= idx + 3'd1;
            end
            if (last_step) begin
                mix_out   <= mix_next;
                out_valid <= 1'b1;
            end else if ((state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MIXER_SAT_EN
    logic sat_next;

    always_comb begin
        mix_next = sum[15:0];
        sat_next = 1'b0;
        if (sum > 20'sd32767) begin
            mix_next = 16'h7FFF;
            sat_next = 1'b1;
        end else if (sum < -20'sd32768) begin
            mix_next = 16'h8000;
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (last_step) begin
            sat_flag <= sat_next;
        end
    end
`else
    // Wrap mode keeps only the low half of the sum; the guard bits are intentionally dropped.
    logic [3:0] unused_sum_hi;

    assign unused_sum_hi = sum[19:16];
    assign mix_next      = sum[15:0];
    assign sat_flag      = 1'b0;
`endif

endmodule

// File: tb/tb_channel_mixer.sv
// Directed self-checking bench for channel_mixer; expectations follow the MIXER_SAT_EN build option.
module tb_channel_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sig_in_1, sig_in_2, sig_in_3, sig_in_4;
    logic [15:0] sig_in_5, sig_in_6, sig_in_7, sig_in_8;
    logic [7:0]  ch_en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mix_out;
    logic        sat_flag;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] vec [8];
    int          lat;

`ifdef MIXER_SAT_EN
    localparam logic [15:0] EXP_POS_MIX = 16'h7FFF;
    localparam logic        EXP_POS_SAT = 1'b1;
    localparam logic [15:0] EXP_NEG_MIX = 16'h8000;
    localparam logic        EXP_NEG_SAT = 1'b1;
`else
    localparam logic [15:0] EXP_POS_MIX = 16'hFFF8;
    localparam logic        EXP_POS_SAT = 1'b0;
    localparam logic [15:0] EXP_NEG_MIX = 16'h0000;
    localparam logic        EXP_NEG_SAT = 1'b0;
`endif

    channel_mixer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in_1  (sig_in_1),
        .sig_in_2  (sig_in_2),
        .sig_in_3  (sig_in_3),
        .sig_in_4  (sig_in_4),
        .sig_in_5  (sig_in_5),
        .sig_in_6  (sig_in_6),
        .sig_in_7  (sig_in_7),
        .sig_in_8  (sig_in_8),
        .ch_en     (ch_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mix_out   (mix_out),
        .sat_flag  (sat_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] val);
        for (int i = 0; i < 8; i++) vec[i] = val;
    endtask

    task automatic drive_inputs;
        sig_in_1 = vec[0]; sig_in_2 = vec[1]; sig_in_3 = vec[2]; sig_in_4 = vec[3];
        sig_in_5 = vec[4]; sig_in_6 = vec[5]; sig_in_7 = vec[6]; sig_in_8 = vec[7];
    endtask

    task automatic scramble_inputs;
        sig_in_1 = 16'($urandom); sig_in_2 = 16'($urandom);
        sig_in_3 = 16'($urandom); sig_in_4 = 16'($urandom);
        sig_in_5 = 16'($urandom); sig_in_6 = 16'($urandom);
        sig_in_7 = 16'($urandom); sig_in_8 = 16'($urandom);
        ch_en    = 8'($urandom);
        in_valid = 1'($urandom);
    endtask

    // Accept vec/en, then count edges until out_valid rises (bounded).
    task automatic send(input string tag, input logic [7:0] en, input bit scramble);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            tick;
            n++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        drive_inputs();
        ch_en    = en;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (scramble) scramble_inputs();
            tick;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, lat, 8);
    endtask

    task automatic release_out(input string tag, input logic [15:0] exp_mix);
        out_ready = 1'b1;
        tick;
        check({tag, "_ov_drop"}, out_valid, 0);
        check({tag, "_in_ready_next"}, in_ready, 1);
        check({tag, "_mix_kept"}, mix_out, exp_mix);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ch_en = '0;
        fill(16'd0);
        drive_inputs();
        tick;
        tick;
        rst_n = 1'b1;

        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_mix", mix_out, 0);
        check("rst_sat", sat_flag, 0);

        // 8 x 1000 with out_ready held high: single-cycle out_valid pulse
        fill(16'd1000);
        send("sum8000", 8'hFF, 1'b0);
        check("sum8000_mix", mix_out, 16'd8000);
        check("sum8000_sat", sat_flag, 0);
        check("sum8000_ov", out_valid, 1);
        tick;
        check("sum8000_ov_1cyc", out_valid, 0);
        check("sum8000_idle", in_ready, 1);

        fill(16'h7FFF);
        send("pos_full", 8'hFF, 1'b0);
        check("pos_full_mix", mix_out, EXP_POS_MIX);
        check("pos_full_sat", sat_flag, EXP_POS_SAT);
        release_out("pos_full", EXP_POS_MIX);

        fill(16'h8000);
        send("neg_full", 8'hFF, 1'b0);
        check("neg_full_mix", mix_out, EXP_NEG_MIX);
        check("neg_full_sat", sat_flag, EXP_NEG_SAT);
        release_out("neg_full", EXP_NEG_MIX);

        fill(16'h1234);
        send("none_en", 8'h00, 1'b0);
        check("none_en_mix", mix_out, 0);
        check("none_en_sat", sat_flag, 0);
        release_out("none_en", 16'h0000);

        // 100 + 300 - 600 - 800 = -1000
        vec = '{16'd100, 16'hFF38, 16'd300, 16'hFE70, 16'd500, 16'hFDA8, 16'd700, 16'hFCE0};
        send("mask_a5", 8'hA5, 1'b0);
        check("mask_a5_mix", mix_out, 16'hFC18);
        release_out("mask_a5", 16'hFC18);

        // -200 - 400 + 500 + 700 = 600
        send("mask_5a", 8'h5A, 1'b0);
        check("mask_5a_mix", mix_out, 16'h0258);
        release_out("mask_5a", 16'h0258);

        // Only channel 1 enabled; inputs churn during accumulation
        fill(16'd30000);
        vec[0] = 16'hFFFB;
        send("isolate", 8'h01, 1'b1);
        check("isolate_mix", mix_out, 16'hFFFB);
        check("isolate_sat", sat_flag, 0);
        release_out("isolate", 16'hFFFB);

        // Back-pressure: output held, new requests refused
        out_ready = 1'b0;
        vec = '{16'd100, 16'hFF38, 16'd300, 16'hFE70, 16'd500, 16'hFDA8, 16'd700, 16'hFCE0};
        send("hold", 8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            fill(16'd7);
            drive_inputs();
            ch_en    = 8'hFF;
            in_valid = 1'b1;
            tick;
            check("hold_ov", out_valid, 1);
            check("hold_mix", mix_out, 16'hFC18);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        release_out("hold", 16'hFC18);
        tick;
        check("hold_no_accept", busy, 0);

        // Reset mid-accumulation abandons the sample
        fill(16'd1000);
        drive_inputs();
        ch_en    = 8'hFF;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("midrst_mix", mix_out, 0);
        check("midrst_sat", sat_flag, 0);
        check("midrst_ov", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (out_valid) seen++;
        end
        check("midrst_no_pulse", seen, 0);

        fill(16'd1);
        send("after_rst", 8'hFF, 1'b0);
        check("after_rst_mix", mix_out, 16'd8);
        release_out("after_rst", 16'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
